// File: rtl/axi_mgr_pkg.sv
// axi_mgr_pkg: AXI encodings, length limit and FSM state types
// shared by axi_mgr and its bench.
package axi_mgr_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] LOCAL_ERR   = RESP_SLVERR;

  localparam int unsigned MAX_LEN    = 255;

  typedef enum logic [1:0] {
    WR_IDLE, WR_AW, WR_W, WR_B
  } wr_state_e;

  typedef enum logic [1:0] {
    RD_IDLE, RD_AR, RD_R
  } rd_state_e;

endpackage

// File: rtl/axi_mgr_if.sv
// axi4_bus_if: full AXI4 AW/W/B/AR/R bundle with
// master (manager) and slave (subordinate) modports.
interface axi4_bus_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned USER_WIDTH = 1
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   aw_id;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;
  logic                  aw_lock;
  logic [3:0]            aw_cache;
  logic [2:0]            aw_prot;
  logic [3:0]            aw_qos;
  logic [3:0]            aw_region;
  logic [5:0]            aw_atop;
  logic [USER_WIDTH-1:0] aw_user;
  logic                  aw_valid;
  logic                  aw_ready;

  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_WIDTH-1:0] w_strb;
  logic                  w_last;
  logic [USER_WIDTH-1:0] w_user;
  logic                  w_valid;
  logic                  w_ready;

  logic [ID_WIDTH-1:0]   b_id;
  logic [1:0]            b_resp;
  logic [USER_WIDTH-1:0] b_user;
  logic                  b_valid;
  logic                  b_ready;

  logic [ID_WIDTH-1:0]   ar_id;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;
  logic                  ar_lock;
  logic [3:0]            ar_cache;
  logic [2:0]            ar_prot;
  logic [3:0]            ar_qos;
  logic [3:0]            ar_region;
  logic [USER_WIDTH-1:0] ar_user;
  logic                  ar_valid;
  logic                  ar_ready;

  logic [ID_WIDTH-1:0]   r_id;
  logic [DATA_WIDTH-1:0] r_data;
  logic [1:0]            r_resp;
  logic                  r_last;
  logic [USER_WIDTH-1:0] r_user;
  logic                  r_valid;
  logic                  r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst,
           aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
           aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst,
           ar_lock, ar_cache, ar_prot, ar_qos, ar_region,
           ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst,
           aw_lock, aw_cache, aw_prot, aw_qos, aw_region,
           aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst,
           ar_lock, ar_cache, ar_prot, ar_qos, ar_region,
           ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/axi_mgr.sv
// axi_mgr: single INCR write/read burst generator on AXI4.
// Define AXI_MGR_BEAT_CHECK_EN to enforce R beat count vs r_last.
module axi_mgr
  import axi_mgr_pkg::*;
#(
  parameter int unsigned AXI_ADDR_WIDTH   = 32,
  parameter int unsigned AXI_DATA_WIDTH   = 64,
  parameter int unsigned AXI_XSIZE        = 8,
  parameter int unsigned DATA_COUNT_WIDTH = 9,
  parameter int unsigned WORD_SIZE_BYTES  = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [1:0]                  req_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_wr_addr_i,
  input  logic [AXI_ADDR_WIDTH-1:0]   axi_rd_addr_i,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_data_i,
  input  logic [DATA_COUNT_WIDTH-1:0] wr_data_count_i,
  input  logic [DATA_COUNT_WIDTH-1:0] rd_data_count_i,
  output logic [1:0]                  rsp_o,
  output logic [1:0]                  wr_err_o,
  output logic [1:0]                  rd_err_o,
  output logic [AXI_DATA_WIDTH-1:0]   axi_data_o,
  axi4_bus_if.master                  axi_mgr_if
);

  localparam int unsigned StrbW = AXI_DATA_WIDTH / 8;
  localparam logic [StrbW-1:0] StrbVal =
    StrbW'((1 << WORD_SIZE_BYTES) - 1);
  localparam logic [2:0] SizeVal = 3'($clog2(AXI_XSIZE));
  localparam logic [DATA_COUNT_WIDTH-1:0] MaxLen =
    DATA_COUNT_WIDTH'(MAX_LEN);

  wr_state_e                 wr_q;
  logic                      aw_valid_q, w_valid_q;
  logic                      w_last_q, b_ready_q;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q;
  logic [AXI_DATA_WIDTH-1:0] wr_data_q;
  logic [7:0]                wr_len_q, wr_cnt_q;
  logic [1:0]                wr_err_q;
  logic                      wr_rsp_q;

  rd_state_e                 rd_q;
  logic                      ar_valid_q, r_ready_q;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q;
  logic [7:0]                rd_len_q;
  logic [1:0]                rd_acc_q, rd_acc_d;
  logic [1:0]                rd_err_q;
  logic                      rd_rsp_q;
  logic [AXI_DATA_WIDTH-1:0] rd_data_q;
  logic                      r_end, r_bad;
`ifdef AXI_MGR_BEAT_CHECK_EN
  logic [7:0]                rd_cnt_q;
`endif

  // Write channel: AW, then len+1 W beats, then B.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q       <= WR_IDLE;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_last_q   <= 1'b0;
      b_ready_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      wr_err_q   <= RESP_OKAY;
      wr_rsp_q   <= 1'b0;
    end else begin
      wr_rsp_q <= 1'b0;
      unique case (wr_q)
        WR_IDLE: if (req_i[0]) begin
          wr_addr_q <= axi_wr_addr_i;
          wr_data_q <= axi_data_i;
          wr_len_q  <= wr_data_count_i[7:0];
          if (wr_data_count_i > MaxLen) begin
            if (!wr_rsp_q) begin
              wr_err_q <= LOCAL_ERR;
              wr_rsp_q <= 1'b1;
            end
          end else begin
            aw_valid_q <= 1'b1;
            wr_q       <= WR_AW;
          end
        end
        WR_AW: if (axi_mgr_if.aw_ready) begin
          aw_valid_q <= 1'b0;
          w_valid_q  <= 1'b1;
          w_last_q   <= (wr_len_q == 8'd0);
          wr_cnt_q   <= '0;
          wr_q       <= WR_W;
        end
        WR_W: if (axi_mgr_if.w_ready) begin
          if (w_last_q) begin
            w_valid_q <= 1'b0;
            w_last_q  <= 1'b0;
            b_ready_q <= 1'b1;
            wr_q      <= WR_B;
          end else begin
            wr_cnt_q <= wr_cnt_q + 8'd1;
            w_last_q <= (wr_cnt_q + 8'd1 == wr_len_q);
          end
        end
        WR_B: if (axi_mgr_if.b_valid) begin
          b_ready_q <= 1'b0;
          wr_err_q  <= axi_mgr_if.b_resp;
          wr_rsp_q  <= 1'b1;
          wr_q      <= WR_IDLE;
        end
        default: wr_q <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_acc_d = (rd_acc_q == RESP_OKAY) ?
               axi_mgr_if.r_resp : rd_acc_q;
`ifdef AXI_MGR_BEAT_CHECK_EN
    r_end = axi_mgr_if.r_last || (rd_cnt_q == rd_len_q);
    r_bad = axi_mgr_if.r_last != (rd_cnt_q == rd_len_q);
`else
    r_end = axi_mgr_if.r_last;
    r_bad = 1'b0;
`endif
  end

  // Read channel: status is accumulated per burst, published at the end.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q       <= RD_IDLE;
      ar_valid_q <= 1'b0;
      r_ready_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_acc_q   <= RESP_OKAY;
      rd_err_q   <= RESP_OKAY;
      rd_rsp_q   <= 1'b0;
      rd_data_q  <= '0;
`ifdef AXI_MGR_BEAT_CHECK_EN
      rd_cnt_q   <= '0;
`endif
    end else begin
      rd_rsp_q <= 1'b0;
      unique case (rd_q)
        RD_IDLE: if (req_i[1]) begin
          rd_addr_q <= axi_rd_addr_i;
          rd_len_q  <= rd_data_count_i[7:0];
          if (rd_data_count_i > MaxLen) begin
            if (!rd_rsp_q) begin
              rd_err_q <= LOCAL_ERR;
              rd_rsp_q <= 1'b1;
            end
          end else begin
            ar_valid_q <= 1'b1;
            rd_acc_q   <= RESP_OKAY;
            rd_q       <= RD_AR;
          end
        end
        RD_AR: if (axi_mgr_if.ar_ready) begin
          ar_valid_q <= 1'b0;
          r_ready_q  <= 1'b1;
`ifdef AXI_MGR_BEAT_CHECK_EN
          rd_cnt_q   <= '0;
`endif
          rd_q       <= RD_R;
        end
        RD_R: if (axi_mgr_if.r_valid) begin
          rd_data_q <= axi_mgr_if.r_data;
          rd_acc_q  <= rd_acc_d;
`ifdef AXI_MGR_BEAT_CHECK_EN
          rd_cnt_q  <= rd_cnt_q + 8'd1;
`endif
          if (r_end) begin
            r_ready_q <= 1'b0;
            rd_err_q  <= r_bad ? LOCAL_ERR : rd_acc_d;
            rd_rsp_q  <= 1'b1;
            rd_q      <= RD_IDLE;
          end
        end
        default: rd_q <= RD_IDLE;
      endcase
    end
  end

  assign rsp_o      = {rd_rsp_q, wr_rsp_q};
  assign wr_err_o   = wr_err_q;
  assign rd_err_o   = rd_err_q;
  assign axi_data_o = rd_data_q;

  assign axi_mgr_if.aw_id     = '0;
  assign axi_mgr_if.aw_addr   = wr_addr_q;
  assign axi_mgr_if.aw_len    = wr_len_q;
  assign axi_mgr_if.aw_size   = SizeVal;
  assign axi_mgr_if.aw_burst  = BURST_INCR;
  assign axi_mgr_if.aw_lock   = 1'b0;
  assign axi_mgr_if.aw_cache  = '0;
  assign axi_mgr_if.aw_prot   = '0;
  assign axi_mgr_if.aw_qos    = '0;
  assign axi_mgr_if.aw_region = '0;
  assign axi_mgr_if.aw_atop   = '0;
  assign axi_mgr_if.aw_user   = '0;
  assign axi_mgr_if.aw_valid  = aw_valid_q;

  assign axi_mgr_if.w_data    = wr_data_q;
  assign axi_mgr_if.w_strb    = StrbVal;
  assign axi_mgr_if.w_last    = w_last_q;
  assign axi_mgr_if.w_user    = '0;
  assign axi_mgr_if.w_valid   = w_valid_q;
  assign axi_mgr_if.b_ready   = b_ready_q;

  assign axi_mgr_if.ar_id     = '0;
  assign axi_mgr_if.ar_addr   = rd_addr_q;
  assign axi_mgr_if.ar_len    = rd_len_q;
  assign axi_mgr_if.ar_size   = SizeVal;
  assign axi_mgr_if.ar_burst  = BURST_INCR;
  assign axi_mgr_if.ar_lock   = 1'b0;
  assign axi_mgr_if.ar_cache  = '0;
  assign axi_mgr_if.ar_prot   = '0;
  assign axi_mgr_if.ar_qos    = '0;
  assign axi_mgr_if.ar_region = '0;
  assign axi_mgr_if.ar_user   = '0;
  assign axi_mgr_if.ar_valid  = ar_valid_q;
  assign axi_mgr_if.r_ready   = r_ready_q;

  logic unused_in;
  assign unused_in = ^{axi_mgr_if.b_id, axi_mgr_if.b_user,
                       axi_mgr_if.r_id, axi_mgr_if.r_user};

endmodule

// File: tb/tb_axi_mgr.sv
// tb_axi_mgr: directed bench for axi_mgr with a reactive
// AXI subordinate and queue-based scoreboard.
module tb_axi_mgr;
  import axi_mgr_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_t;
  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } w_t;
  typedef struct packed {
    logic [1:0]  err;
    logic [63:0] data;
  } rr_t;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  req_i = '0;
  logic [31:0] wr_addr = '0, rd_addr = '0;
  logic [63:0] wdata = '0;
  logic [8:0]  wr_cnt = '0, rd_cnt = '0;
  logic [1:0]  rsp_o, wr_err_o, rd_err_o;
  logic [63:0] rdata;

  int checks = 0;
  int errors = 0;

  logic        rand_en = 1'b0;
  logic [1:0]  b_resp_cfg = RESP_OKAY;
  logic [63:0] r_base = '0;
  logic [7:0]  rresp_pk = '0;
  logic        r_act;
  logic [7:0]  r_len, r_idx;

  ax_t  exp_aw[$], exp_ar[$];
  w_t   exp_w[$];
  logic [1:0] exp_wrsp[$];
  rr_t  exp_rrsp[$];
  logic [63:0] model_rdata = '0;

  always #5 clk = ~clk;

  axi4_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) bus ();

  axi_mgr dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .req_i           (req_i),
    .axi_wr_addr_i   (wr_addr),
    .axi_rd_addr_i   (rd_addr),
    .axi_data_i      (wdata),
    .wr_data_count_i (wr_cnt),
    .rd_data_count_i (rd_cnt),
    .rsp_o           (rsp_o),
    .wr_err_o        (wr_err_o),
    .rd_err_o        (rd_err_o),
    .axi_data_o      (rdata),
    .axi_mgr_if      (bus)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Subordinate: registered responder, optional random stalls.
  always @(posedge clk) begin
    if (rst_i) begin
      bus.aw_ready <= 1'b0;
      bus.w_ready  <= 1'b0;
      bus.ar_ready <= 1'b0;
      bus.b_valid  <= 1'b0;
      bus.b_resp   <= '0;
      bus.b_id     <= '0;
      bus.b_user   <= '0;
      bus.r_valid  <= 1'b0;
      bus.r_data   <= '0;
      bus.r_resp   <= '0;
      bus.r_last   <= 1'b0;
      bus.r_id     <= '0;
      bus.r_user   <= '0;
      r_act        <= 1'b0;
      r_len        <= '0;
      r_idx        <= '0;
    end else begin
      bus.aw_ready <= rand_en ? 1'($urandom_range(1)) : 1'b1;
      bus.w_ready  <= rand_en ? 1'($urandom_range(1)) : 1'b1;
      bus.ar_ready <= rand_en ? 1'($urandom_range(1)) : 1'b1;
      if (bus.w_valid && bus.w_ready && bus.w_last) begin
        bus.b_valid <= 1'b1;
        bus.b_resp  <= b_resp_cfg;
      end else if (bus.b_valid && bus.b_ready) begin
        bus.b_valid <= 1'b0;
      end
      if (bus.ar_valid && bus.ar_ready) begin
        r_act <= 1'b1;
        r_len <= bus.ar_len;
        r_idx <= '0;
      end else if (!bus.r_valid || bus.r_ready) begin
        if (r_act && (!rand_en || $urandom_range(1) == 1)) begin
          bus.r_valid <= 1'b1;
          bus.r_data  <= r_base + 64'(r_idx);
          bus.r_resp  <= rresp_pk[{r_idx[1:0], 1'b0} +: 2];
          bus.r_last  <= (r_idx == r_len);
          r_idx       <= r_idx + 8'd1;
          if (r_idx == r_len) r_act <= 1'b0;
        end else begin
          bus.r_valid <= 1'b0;
        end
      end
    end
  end

  // Monitor at negedge: values here are what the next edge samples.
  ax_t  m_ax;
  w_t   m_w;
  rr_t  m_rr;
  logic aw_hold, w_hold, ar_hold;
  logic [39:0] aw_prev, ar_prev;
  logic [64:0] w_prev;
  logic [1:0]  prev_rsp;
  int          w_hs_cnt = 0;

  always @(negedge clk) begin
    if (rst_i) begin
      aw_hold  <= 1'b0;
      w_hold   <= 1'b0;
      ar_hold  <= 1'b0;
      prev_rsp <= '0;
    end else begin
      if (bus.aw_valid)
        chk("aw_expected", 64'(exp_aw.size() != 0), 1);
      if (bus.ar_valid)
        chk("ar_expected", 64'(exp_ar.size() != 0), 1);
      if (bus.w_valid)
        chk("w_expected", 64'(exp_w.size() != 0), 1);
      if (aw_hold) begin
        chk("aw_stable_v", bus.aw_valid, 1);
        chk("aw_stable", {bus.aw_addr, bus.aw_len}, aw_prev);
      end
      if (ar_hold) begin
        chk("ar_stable_v", bus.ar_valid, 1);
        chk("ar_stable", {bus.ar_addr, bus.ar_len}, ar_prev);
      end
      if (w_hold) begin
        chk("w_stable_v", bus.w_valid, 1);
        chk("w_stable_d", bus.w_data, w_prev[64:1]);
        chk("w_stable_l", bus.w_last, w_prev[0]);
      end
      if (bus.aw_valid && bus.aw_ready && exp_aw.size() != 0) begin
        m_ax = exp_aw.pop_front();
        chk("aw_addr", bus.aw_addr, m_ax.addr);
        chk("aw_len", bus.aw_len, m_ax.len);
        chk("aw_size", bus.aw_size, 3);
        chk("aw_burst", bus.aw_burst, BURST_INCR);
      end
      if (bus.ar_valid && bus.ar_ready && exp_ar.size() != 0) begin
        m_ax = exp_ar.pop_front();
        chk("ar_addr", bus.ar_addr, m_ax.addr);
        chk("ar_len", bus.ar_len, m_ax.len);
        chk("ar_size", bus.ar_size, 3);
        chk("ar_burst", bus.ar_burst, BURST_INCR);
      end
      if (bus.w_valid && bus.w_ready && exp_w.size() != 0) begin
        m_w = exp_w.pop_front();
        chk("w_data", bus.w_data, m_w.data);
        chk("w_last", bus.w_last, m_w.last);
        chk("w_strb", bus.w_strb, 8'h0F);
        w_hs_cnt <= w_hs_cnt + 1;
      end
      if (rsp_o[0]) begin
        chk("wr_rsp_expected", 64'(exp_wrsp.size() != 0), 1);
        if (exp_wrsp.size() != 0)
          chk("wr_err", wr_err_o, exp_wrsp.pop_front());
      end
      if (rsp_o[1]) begin
        chk("rd_rsp_expected", 64'(exp_rrsp.size() != 0), 1);
        if (exp_rrsp.size() != 0) begin
          m_rr = exp_rrsp.pop_front();
          chk("rd_err", rd_err_o, m_rr.err);
          chk("rd_data", rdata, m_rr.data);
        end
      end
      if (prev_rsp != 2'b00)
        chk("rsp_single_cycle", rsp_o & prev_rsp, 0);
      aw_hold  <= bus.aw_valid && !bus.aw_ready;
      ar_hold  <= bus.ar_valid && !bus.ar_ready;
      w_hold   <= bus.w_valid && !bus.w_ready;
      aw_prev  <= {bus.aw_addr, bus.aw_len};
      ar_prev  <= {bus.ar_addr, bus.ar_len};
      w_prev   <= {bus.w_data, bus.w_last};
      prev_rsp <= rsp_o;
    end
  end

  task automatic setup_wr(input logic [31:0] a,
                          input logic [63:0] d,
                          input int cnt,
                          input logic [1:0] br);
    wr_addr    = a;
    wdata      = d;
    wr_cnt     = 9'(cnt);
    b_resp_cfg = br;
    if (cnt > 255) begin
      exp_wrsp.push_back(LOCAL_ERR);
    end else begin
      exp_aw.push_back(ax_t'{a, 8'(cnt)});
      for (int i = 0; i <= cnt; i++)
        exp_w.push_back(w_t'{d, (i == cnt)});
      exp_wrsp.push_back(br);
    end
  endtask

  task automatic setup_rd(input logic [31:0] a,
                          input int cnt,
                          input logic [63:0] base,
                          input logic [7:0] rr);
    logic [1:0] e;
    rd_addr  = a;
    rd_cnt   = 9'(cnt);
    r_base   = base;
    rresp_pk = rr;
    if (cnt > 255) begin
      exp_rrsp.push_back(rr_t'{LOCAL_ERR, model_rdata});
    end else begin
      e = RESP_OKAY;
      for (int i = 0; i <= cnt; i++)
        if (e == RESP_OKAY) e = rr[2*i +: 2];
      model_rdata = base + 64'(cnt);
      exp_ar.push_back(ax_t'{a, 8'(cnt)});
      exp_rrsp.push_back(rr_t'{e, model_rdata});
    end
  endtask

  task automatic go(input logic [1:0] m);
    @(negedge clk);
    req_i = m;
    @(negedge clk);
    req_i = 2'b00;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_aw.size() + exp_w.size() + exp_ar.size() +
            exp_wrsp.size() + exp_rrsp.size()) != 0 &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 64'(exp_aw.size() + exp_w.size() +
        exp_ar.size() + exp_wrsp.size() + exp_rrsp.size()), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_rsp"}, rsp_o, 0);
    chk({tag, "_wr_err"}, wr_err_o, 0);
    chk({tag, "_rd_err"}, rd_err_o, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_valids"}, {bus.aw_valid, bus.w_valid,
        bus.ar_valid, bus.b_ready, bus.r_ready}, 0);
  endtask

  initial begin
    logic got;
    int   base;

    repeat (2) @(negedge clk);
    chk_reset_outs("reset");
    rst_i = 1'b0;
    @(negedge clk);

    setup_wr(32'h5000, 64'hDEADBEEF0B501E7E, 0, RESP_OKAY);
    go(2'b01);
    wait_idle(100);

    setup_rd(32'h6000, 0, 64'h1234, 8'h00);
    go(2'b10);
    wait_idle(100);

    setup_wr(32'h5100, 64'h1, 257, RESP_OKAY);
    go(2'b01);
    chk("illegal_wr_pulse", rsp_o[0], 1);
    chk("illegal_wr_aw", bus.aw_valid, 0);
    wait_idle(20);

    setup_rd(32'h6100, 300, 64'h0, 8'h00);
    go(2'b10);
    chk("illegal_rd_pulse", rsp_o[1], 1);
    chk("illegal_rd_ar", bus.ar_valid, 0);
    wait_idle(20);

    rand_en = 1'b1;
    setup_wr(32'h7000, 64'h0123456789ABCDEF, 3, RESP_OKAY);
    setup_rd(32'h8000, 3, 64'hA000, 8'h00);
    go(2'b11);
    wait_idle(400);

    setup_wr(32'h7100, 64'h55AA55AA55AA55AA, 1, RESP_SLVERR);
    setup_rd(32'h8100, 2, 64'hB000, 8'h0C);
    go(2'b11);
    wait_idle(400);
    rand_en = 1'b0;

    setup_wr(32'h9000, 64'hCAFE, 3, RESP_OKAY);
    base = w_hs_cnt;
    go(2'b01);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (w_hs_cnt >= base + 1) got = 1'b1;
      else @(negedge clk);
    end
    chk("rst_reach_w2", got, 1);
    chk("rst_in_w", bus.w_valid, 1);
    rst_i = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    exp_aw.delete();
    exp_w.delete();
    exp_wrsp.delete();
    model_rdata = '0;
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", rsp_o, 0);
    end

    setup_wr(32'hA000, 64'h77, 0, RESP_OKAY);
    setup_wr(32'hA000, 64'h77, 0, RESP_OKAY);
    @(negedge clk);
    req_i = 2'b01;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      got = rsp_o[0];
    end
    chk("b2b_first_rsp", got, 1);
    @(negedge clk);
    chk("b2b_restart_aw", bus.aw_valid, 1);
    req_i = 2'b00;
    wait_idle(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
